// File: rtl/ram_port_arbiter.sv
// Round-robin multi-channel front end for the word-indexed simulation RAM.
// Define RAM_ARB_MISALIGN_CHK_EN to flag misaligned / below-base accesses.
module ram_port_arbiter #(
  parameter int          NUM_CH    = 2,
  parameter int          ADDR_W    = 64,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          DATA_W    = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [2*NUM_CH-1:0]      req_size,
  input  logic [NUM_CH-1:0]        req_signed,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [DATA_W*NUM_CH-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     ram_ren,
  output logic [ADDR_W-1:0]        ram_ridx,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_widx,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic [DATA_W-1:0]        ram_wmask
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic {
    S_IDLE,
    S_RSP
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       rr_q, rr_d;
  logic [NUM_CH-1:0]   gnt;
  logic                gnt_any;
  logic [CW-1:0]       gnt_ch;

  logic [NUM_CH-1:0]   rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic [1:0]          sel_size;
  logic                sel_sgn;
  logic [DATA_W-1:0]   sel_wdata;
  logic [ADDR_W-1:0]   off;
  logic [2:0]          lane;
  logic [5:0]          shamt;
  logic [7:0]          bmask;
  logic [7:0]          lmask;
  logic [DATA_W-1:0]   rd_sh;
  logic [DATA_W-1:0]   ld_data;
  logic                chk_bad;

  // Search from rr_q upward with wrap; first valid channel wins.
  always_comb begin
    int c;
    c       = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_ch  = '0;
    rr_d    = rr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(rr_q) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!gnt_any && rst_n && req_valid[c]) begin
        gnt_any = 1'b1;
        gnt_ch  = CW'(c);
        gnt[c]  = 1'b1;
      end
    end
    if (gnt_any) begin
      rr_d = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + CW'(1);
    end
  end

  assign req_ready = gnt;

  assign sel_addr  = req_addr[int'(gnt_ch)*ADDR_W +: ADDR_W];
  assign sel_we    = req_we[gnt_ch];
  assign sel_size  = req_size[2*int'(gnt_ch) +: 2];
  assign sel_sgn   = req_signed[gnt_ch];
  assign sel_wdata = req_wdata[int'(gnt_ch)*DATA_W +: DATA_W];

  assign off   = sel_addr - BASE;
  assign lane  = sel_addr[2:0];
  assign shamt = {lane, 3'b000};

  always_comb begin
    bmask = 8'hFF;
    unique case (sel_size)
      2'd0:    bmask = 8'h01;
      2'd1:    bmask = 8'h03;
      2'd2:    bmask = 8'h0F;
      default: bmask = 8'hFF;
    endcase
  end

  // Bytes pushed past lane 7 fall off the top of the word.
  assign lmask = bmask << lane;

  always_comb begin
    ram_wmask = '0;
    for (int b = 0; b < 8; b++) begin
      ram_wmask[8*b +: 8] = {8{lmask[b]}};
    end
  end

  assign ram_wdata = sel_wdata << shamt;
  assign rd_sh     = ram_rdata >> shamt;

  always_comb begin
    ld_data = rd_sh;
    unique case (sel_size)
      2'd0:    ld_data = {{56{sel_sgn & rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    ld_data = {{48{sel_sgn & rd_sh[15]}}, rd_sh[15:0]};
      2'd2:    ld_data = {{32{sel_sgn & rd_sh[31]}}, rd_sh[31:0]};
      default: ld_data = rd_sh;
    endcase
  end

`ifdef RAM_ARB_MISALIGN_CHK_EN
  logic [2:0] szm;
  assign szm = (sel_size == 2'd0) ? 3'd0 :
               (sel_size == 2'd1) ? 3'd1 :
               (sel_size == 2'd2) ? 3'd3 : 3'd7;
  assign chk_bad = gnt_any &&
                   (((lane & szm) != 3'd0) || (sel_addr < BASE));
`else
  assign chk_bad = 1'b0;
`endif

  assign ram_ren  = gnt_any & ~sel_we & ~chk_bad;
  assign ram_wen  = gnt_any &  sel_we & ~chk_bad;
  assign ram_ridx = off >> 3;
  assign ram_widx = off >> 3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      rsp_valid_q <= gnt;
      rsp_err_q   <= chk_bad;
      rsp_rdata_q <= (gnt_any && !sel_we && !chk_bad) ? ld_data : '0;
      unique case (state_q)
        S_IDLE:  state_q <= gnt_any ? S_RSP : S_IDLE;
        S_RSP:   state_q <= gnt_any ? S_RSP : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q & {NUM_CH{state_q == S_RSP}};
  assign rsp_rdata = rsp_rdata_q;
`ifdef RAM_ARB_MISALIGN_CHK_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: byte-level memory model,
// round-robin grant model, response queue checked by a monitor.
module tb_ram_port_arbiter;

  localparam int NCH = 3;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_valid, req_ready, req_we, req_signed, rsp_valid;
  logic [2*NCH-1:0]  req_size;
  logic [64*NCH-1:0] req_addr, req_wdata;
  logic [63:0]       rsp_rdata, ram_ridx, ram_rdata, ram_widx;
  logic [63:0]       ram_wdata, ram_wmask;
  logic              rsp_err, ram_ren, ram_wen;

  ram_port_arbiter #(
    .NUM_CH(NCH), .ADDR_W(64), .BASE_ADDR(BASE), .DATA_W(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_ren(ram_ren), .ram_ridx(ram_ridx),
    .ram_rdata(ram_rdata), .ram_wen(ram_wen), .ram_widx(ram_widx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask)
  );

  logic [63:0] ram [0:15];
  assign ram_rdata = ram[ram_ridx[3:0]];
  always @(posedge clk)
    if (ram_wen)
      ram[ram_widx[3:0]] <= (ram[ram_widx[3:0]] & ~ram_wmask) |
                            (ram_wdata & ram_wmask);

  logic [7:0] ref_mem [0:127];

  typedef struct {
    int          ch;
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rr_m  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic is_bad(input logic [63:0] a, input logic [1:0] sz);
`ifdef RAM_ARB_MISALIGN_CHK_EN
    int ln;
    ln = int'(a[2:0]);
    return ((ln % (1 << sz)) != 0) || (a < BASE);
`else
    return (a === 64'hx) && (sz === 2'bx);
`endif
  endfunction

  task automatic model_access(input int ch, output exp_t e);
    logic [63:0] a, wd, val, off;
    logic [1:0]  sz;
    logic        we, sg;
    int          n, ln, w;
    a   = req_addr[64*ch +: 64];
    wd  = req_wdata[64*ch +: 64];
    sz  = req_size[2*ch +: 2];
    we  = req_we[ch];
    sg  = req_signed[ch];
    n   = 1 << sz;
    ln  = int'(a[2:0]);
    e.ch   = ch;
    e.err  = is_bad(a, sz);
    e.data = '0;
    if (!e.err) begin
      off = (a - BASE) >> 3;
      w   = int'(off[3:0]);
      val = '0;
      for (int b = 0; b < n; b++) begin
        if (ln + b < 8) begin
          if (we) ref_mem[w*8 + ln + b] = wd[8*b +: 8];
          else    val[8*b +: 8] = ref_mem[w*8 + ln + b];
        end
      end
      if (!we && sg && n < 8 && val[8*n-1])
        val = val | ~((64'd1 << (8*n)) - 64'd1);
      if (!we) e.data = val;
    end
  endtask

  task automatic settle(output int g);
    logic [NCH-1:0] exp_rdy;
    exp_t e;
    int c;
    #1;
    g = -1;
    exp_rdy = '0;
    for (int i = 0; i < NCH; i++) begin
      c = (rr_m + i) % NCH;
      if (g < 0 && req_valid[c]) g = c;
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      model_access(g, e);
      sb.push_back(e);
      rr_m = (g + 1) % NCH;
    end
  endtask

  task automatic op(input int ch, input logic we, input logic [1:0] sz,
                    input logic sg, input logic [63:0] a,
                    input logic [63:0] wd);
    int g;
    @(negedge clk);
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_we[ch] = we;
    req_size[2*ch +: 2] = sz;
    req_signed[ch] = sg;
    req_addr[64*ch +: 64] = a;
    req_wdata[64*ch +: 64] = wd;
    settle(g);
  endtask

  initial begin
    logic [NCH-1:0] oh;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          chk("rsp_spurious", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          oh = '0;
          oh[e.ch] = 1'b1;
          chk("rsp_valid", 64'(rsp_valid), 64'(oh));
          chk("rsp_rdata", rsp_rdata, e.data);
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end else if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_missing", 64'(rsp_valid), 64'(1) << e.ch);
      end
    end
  end

  initial begin
    int g;
    int last_g;
    req_valid = '0; req_we = '0; req_size = '0; req_signed = '0;
    req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 16; w++) begin
      ram[w] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = ram[w][8*b +: 8];
    end
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    req_valid = 3'b010;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_ren", 64'(ram_ren), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 1'b1, 2'd3, 1'b0, BASE + 64'h10, 64'h1122334455667788);
    chk("st_wen", 64'(ram_wen), 64'd1);
    chk("st_widx", ram_widx, 64'd2);
    chk("st_wmask", ram_wmask, '1);
    chk("st_wdata", ram_wdata, 64'h1122334455667788);
    op(0, 1'b0, 2'd3, 1'b0, BASE + 64'h10, 64'd0);
    chk("ld_ren", 64'(ram_ren), 64'd1);
    chk("ld_ridx", ram_ridx, 64'd2);

    op(1, 1'b1, 2'd3, 1'b0, BASE + 64'h10, 64'h80AABBCCDDEEFF00);
    op(0, 1'b0, 2'd0, 1'b1, BASE + 64'h17, 64'd0);
    op(1, 1'b0, 2'd0, 1'b0, BASE + 64'h17, 64'd0);

    op(1, 1'b1, 2'd1, 1'b0, BASE + 64'h2, 64'h0000_0000_0000_BEEF);
    chk("half_wmask", ram_wmask, 64'h0000_0000_FFFF_0000);
    chk("half_lanes", ram_wdata & ram_wmask, 64'h0000_0000_BEEF_0000);
    op(2, 1'b0, 2'd1, 1'b1, BASE + 64'h2, 64'd0);

    op(0, 1'b0, 2'd2, 1'b0, BASE + 64'h6, 64'd0);
`ifdef RAM_ARB_MISALIGN_CHK_EN
    chk("mis_ren", 64'(ram_ren), 64'd0);
    op(1, 1'b1, 2'd3, 1'b0, BASE - 64'h8, 64'hDEAD);
    chk("below_wen", 64'(ram_wen), 64'd0);
`else
    chk("mis_ren", 64'(ram_ren), 64'd1);
`endif
    @(negedge clk);
    req_valid = '0;
    settle(g);

    last_g = -1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (last_g >= 0) req_valid[last_g] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (!req_valid[c]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_valid[c] = 1'b1;
            req_we[c] = 1'($urandom_range(0, 1));
            req_size[2*c +: 2] = 2'($urandom_range(0, 3));
            req_signed[c] = 1'($urandom_range(0, 1));
            req_addr[64*c +: 64] = BASE + 64'($urandom_range(0, 127));
            req_wdata[64*c +: 64] = {$urandom, $urandom};
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[c] = 1'b0;
        end
      end
      settle(g);
      last_g = g;
    end

    @(negedge clk);
    req_valid = 3'b010;
    req_we = '0;
    settle(g);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_ren", 64'(ram_ren), 64'd0);
    chk("arst_wen", 64'(ram_wen), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("arst_rsp_rdata", rsp_rdata, 64'd0);
    sb.delete();
    rr_m = 0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    req_we = '0;
    req_size = {NCH{2'd3}};
    req_addr = {NCH{BASE + 64'h20}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 3'b011;
      settle(g);
      chk("alt_grant", 64'(req_ready), 64'(1) << (i % 2));
    end
    @(negedge clk);
    req_valid = '0;
    settle(g);
    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
